// File: rtl/tap_seq_if.sv
// tap_seq_if: bus bundle between the tap sequencer and its controller.
// Carries the divider tap bus, table configuration, run control and the
// gated output. Optional edge_count is present when TAP_SEQ_EDGE_CNT_EN
// is defined.
interface tap_seq_if #(
  parameter int NUM_SLOTS = 4,
  parameter int DWELL_W   = 8
);
  localparam int AW = $clog2(NUM_SLOTS);

  logic [7:0]         taps_in;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [2:0]         cfg_tap;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_ready;
  logic [AW-1:0]      seq_len;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               seq_out;
  logic               seq_active;
  logic [AW-1:0]      slot_idx;
  logic               done;
`ifdef TAP_SEQ_EDGE_CNT_EN
  logic [15:0]        edge_count;
`endif

  // Controller side: drives taps, configuration and run control.
  modport master (
    output taps_in, cfg_we, cfg_addr, cfg_tap, cfg_dwell, seq_len, loop_en, start, stop,
    input  cfg_ready, seq_out, seq_active, slot_idx, done
`ifdef TAP_SEQ_EDGE_CNT_EN
    , edge_count
`endif
  );

  // Sequencer side.
  modport slave (
    input  taps_in, cfg_we, cfg_addr, cfg_tap, cfg_dwell, seq_len, loop_en, start, stop,
    output cfg_ready, seq_out, seq_active, slot_idx, done
`ifdef TAP_SEQ_EDGE_CNT_EN
    , edge_count
`endif
  );
endinterface

// File: rtl/tap_sequencer.sv
// tap_sequencer: steps through a programmable slot table; each slot picks
// one divider tap and emits a fixed number of whole pulses of it on
// seq_out. Define TAP_SEQ_EDGE_CNT_EN to add the 16-bit edge_count output.
module tap_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int DWELL_W   = 8
) (
  input logic     clk,
  input logic     rst_n,
  tap_seq_if.slave bus
);
  localparam int AW = $clog2(NUM_SLOTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [AW-1:0]      slot_reg, slot_next;
  logic [AW-1:0]      last_reg;
  logic [DWELL_W-1:0] count_reg, count_next;
  logic               tap_q_reg;
  logic               seq_out_reg, seq_out_next;

  logic [2:0]         tab_tap_reg   [NUM_SLOTS];
  logic [DWELL_W-1:0] tab_dwell_reg [NUM_SLOTS];

  logic [2:0]         cur_tap;
  logic [DWELL_W-1:0] cur_dwell;
  logic               tap_now, tap_rise, tap_fall;
  logic               start_ok;
  logic [1:0]         adv_state;
  logic [AW-1:0]      adv_slot;

  assign cur_tap   = tab_tap_reg[slot_reg];
  assign cur_dwell = tab_dwell_reg[slot_reg];
  assign tap_now   = bus.taps_in[cur_tap];
  assign tap_rise  = tap_now & ~tap_q_reg;
  assign tap_fall  = ~tap_now & tap_q_reg;
  assign start_ok  = (state_reg == S_IDLE) && bus.start && !bus.stop;

  // Slot table; each slot resets to {tap=i mod 8, dwell=1} and is writable only while idle.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tab_tap_reg[gi]   <= 3'(gi % 8);
          tab_dwell_reg[gi] <= DWELL_W'(1);
        end else if (state_reg == S_IDLE && bus.cfg_we && bus.cfg_addr == AW'(gi)) begin
          tab_tap_reg[gi]   <= bus.cfg_tap;
          tab_dwell_reg[gi] <= bus.cfg_dwell;
        end
      end
    end
  endgenerate

  // Where to go when the current slot is finished (or skipped).
  always_comb begin
    adv_state = S_DONE;
    adv_slot  = slot_reg;
    if (slot_reg < last_reg) begin
      adv_state = S_ARM;
      adv_slot  = slot_reg + AW'(1);
    end else if (bus.loop_en) begin
      adv_state = S_ARM;
      adv_slot  = '0;
    end
  end

  // Sequencer next-state; stop from any busy state overrides everything.
  always_comb begin
    state_next   = state_reg;
    slot_next    = slot_reg;
    count_next   = count_reg;
    seq_out_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_ok) begin
          slot_next  = '0;
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (cur_dwell == '0) begin
          state_next = adv_state;
          slot_next  = adv_slot;
        end else if (!tap_now) begin
          // Entering on a low tap guarantees the first pulse is full width.
          state_next = S_RUN;
          count_next = '0;
        end
      end
      S_RUN: begin
        seq_out_next = tap_now;
        if (tap_rise && count_reg != cur_dwell) begin
          count_next = count_reg + DWELL_W'(1);
        end
        // Leave only on a falling edge so the last pulse is never cut short.
        if (tap_fall && count_reg == cur_dwell) begin
          state_next = adv_state;
          slot_next  = adv_slot;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (bus.stop && state_reg != S_IDLE) begin
      state_next   = S_IDLE;
      seq_out_next = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      slot_reg    <= '0;
      last_reg    <= '0;
      count_reg   <= '0;
      tap_q_reg   <= 1'b0;
      seq_out_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      slot_reg    <= slot_next;
      count_reg   <= count_next;
      tap_q_reg   <= tap_now;
      seq_out_reg <= seq_out_next;
      if (start_ok) begin
        last_reg <= bus.seq_len;
      end
    end
  end

  assign bus.seq_out    = seq_out_reg;
  assign bus.seq_active = (state_reg == S_ARM) || (state_reg == S_RUN);
  assign bus.slot_idx   = slot_reg;
  assign bus.done       = (state_reg == S_DONE);
  assign bus.cfg_ready  = (state_reg == S_IDLE);

`ifdef TAP_SEQ_EDGE_CNT_EN
  logic [15:0] edge_cnt_reg;

  // Saturating count of seq_out rising edges since the last accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_reg <= '0;
    end else if (start_ok) begin
      edge_cnt_reg <= '0;
    end else if (seq_out_next && !seq_out_reg && edge_cnt_reg != 16'hFFFF) begin
      edge_cnt_reg <= edge_cnt_reg + 16'd1;
    end
  end

  assign bus.edge_count = edge_cnt_reg;
`endif
endmodule

// File: tb/tb_tap_sequencer.sv
// tb_tap_sequencer: randomized and directed runs of tap_sequencer. A slot
// table model expands each run into the expected list of pulses (width,
// slot, low gap inside a burst) plus a done event; a negedge monitor pops
// and compares whenever seq_out falls or done is seen.
module tb_tap_sequencer;
  localparam int NS = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tap_seq_if #(.NUM_SLOTS(NS), .DWELL_W(DW)) bus ();

  tap_sequencer #(.NUM_SLOTS(NS), .DWELL_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int kind;   // 0 = pulse, 1 = done
    int slot;
    int width;
    int gap;    // expected low cycles before this pulse, -1 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_tap[NS];
  int   m_dwell[NS];
  bit   mon_en = 1'b0;
  int   pulses_seen = 0;
  int   slot1_cycles = 0;

  logic [7:0] div = 8'd0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Free-running divider model: bit n toggles every 2^n cycles.
  initial begin
    forever begin
      @(negedge clk);
      div = div + 8'd1;
      bus.taps_in = div;
    end
  end

  // Monitor: measures pulses on seq_out and pops the scoreboard.
  bit   m_prev = 1'b0;
  int   m_hi = 0, m_lo = 0, m_rslot = 0, m_rgap = 0;
  exp_t m_e;
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      m_prev = 1'b0;
      m_hi = 0;
      m_lo = 0;
    end else begin
      if (bus.seq_out) begin
        if (!m_prev) begin
          m_rslot = int'(bus.slot_idx);
          m_rgap  = m_lo;
        end
        m_hi++;
        chk("active_while_out", int'(bus.seq_active), 1);
      end else begin
        if (m_prev) begin
          if (exp_q.size() == 0) begin
            chk("pulse_unexpected", 1, 0);
          end else begin
            m_e = exp_q.pop_front();
            chk("pulse_kind", 0, m_e.kind);
            chk("pulse_width", m_hi, m_e.width);
            chk("pulse_slot", m_rslot, m_e.slot);
            if (m_e.gap >= 0) chk("pulse_gap", m_rgap, m_e.gap);
            pulses_seen++;
          end
          m_hi = 0;
          m_lo = 0;
        end
        m_lo++;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          chk("done_kind", 1, m_e.kind);
          chk("done_out_low", int'(bus.seq_out), 0);
          $display("done event pulses_seen=%0d t=%0t", pulses_seen, $time);
        end
      end
      m_prev = bus.seq_out;
    end
  end

  // Time spent on slot 1 while busy (skip-timing check).
  always @(negedge clk) begin
    if (bus.seq_active && bus.slot_idx == 2'd1) slot1_cycles++;
  end

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_tap[i]   = i % 8;
      m_dwell[i] = 1;
    end
  endtask

  task automatic cfg_write(input int a, input int t, input int d);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 2'(a);
    bus.cfg_tap   = 3'(t);
    bus.cfg_dwell = 8'(d);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_tap[a]   = t;
    m_dwell[a] = d;
  endtask

  task automatic push_run(input int len);
    exp_t e;
    for (int s = 0; s <= len; s++) begin
      for (int p = 0; p < m_dwell[s]; p++) begin
        e.kind  = 0;
        e.slot  = s;
        e.width = 1 << m_tap[s];
        e.gap   = (p == 0) ? -1 : (1 << m_tap[s]);
        exp_q.push_back(e);
      end
    end
    e.kind = 1; e.slot = 0; e.width = 0; e.gap = -1;
    exp_q.push_back(e);
  endtask

  task automatic launch(input int len, input bit lp, input bit push);
    if (push) push_run(len);
    $display("run len=%0d loop=%0d expected_events=%0d", len + 1, lp, exp_q.size());
    @(negedge clk);
    bus.seq_len = 2'(len);
    bus.loop_en = lp;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.cfg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("run_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_out_high(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.seq_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, int'(seen), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    exp_t e;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_tap = 0; bus.cfg_dwell = 0;
    bus.seq_len = 0; bus.loop_en = 0; bus.start = 0; bus.stop = 0;
    bus.taps_in = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_seq_out", int'(bus.seq_out), 0);
    chk("rst_active", int'(bus.seq_active), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_slot", int'(bus.slot_idx), 0);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Reset table: slot i = {tap i, dwell 1}.
    launch(3, 0, 1);
    wait_idle(2000);

    // Three single-cycle pulses of tap0.
    cfg_write(0, 0, 3);
    launch(0, 0, 1);
    wait_idle(500);
    @(negedge clk);
    chk("after_done_active", int'(bus.seq_active), 0);

    // Skipped middle slot.
    cfg_write(0, 1, 2);
    cfg_write(1, 0, 0);
    cfg_write(2, 2, 1);
    slot1_cycles = 0;
    launch(2, 0, 1);
    wait_idle(500);
    chk("skip_one_cycle", slot1_cycles, 1);

    // Looping until loop_en drops: one more pass after the drop.
    cfg_write(0, 0, 1);
    e.kind = 0; e.slot = 0; e.width = 1; e.gap = -1;
    for (int i = 0; i < 6; i++) exp_q.push_back(e);
    pulses_seen = 0;
    launch(0, 1, 0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (pulses_seen >= 5) break;
    end
    chk("loop_pulses", pulses_seen, 5);
    bus.loop_en = 1'b0;
    e.kind = 1;
    exp_q.push_back(e);
    wait_idle(300);

    // Stop mid-pulse of a tap3 burst, then replay.
    cfg_write(0, 3, 2);
    mon_en = 1'b0;
    launch(0, 0, 0);
    wait_out_high("stop_saw_pulse");
    repeat (2) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_out_low", int'(bus.seq_out), 0);
    chk("stop_inactive", int'(bus.seq_active), 0);
    chk("stop_cfg_ready", int'(bus.cfg_ready), 1);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.seq_active) dcnt++;
    end
    chk("stop_no_done", dcnt, 0);
    mon_en = 1'b1;
    launch(0, 0, 1);
    wait_idle(500);

    // Table write while running is ignored.
    cfg_write(0, 1, 2);
    launch(0, 0, 1);
    repeat (3) @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 0; bus.cfg_tap = 3'd5; bus.cfg_dwell = 8'd7;
    chk("run_cfg_ready", int'(bus.cfg_ready), 0);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_idle(500);
    launch(0, 0, 1);
    wait_idle(500);

    // start with stop in IDLE stays idle.
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.seq_active || bus.done || !bus.cfg_ready) dcnt++;
    end
    chk("start_stop_idle", dcnt, 0);

    // All active slots skipped: only done.
    cfg_write(0, 2, 0);
    cfg_write(1, 3, 0);
    launch(1, 0, 1);
    wait_idle(100);

    // Randomized tables.
    for (int it = 0; it < 10; it++) begin
      for (int s = 0; s < NS; s++) cfg_write(s, $urandom_range(0, 4), $urandom_range(0, 3));
      launch($urandom_range(0, NS - 1), 0, 1);
      wait_idle(3000);
    end

    // Asynchronous reset mid-run restores the reset table.
    cfg_write(0, 2, 3);
    mon_en = 1'b0;
    launch(0, 0, 0);
    wait_out_high("rst_saw_pulse");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_low", int'(bus.seq_out), 0);
    chk("arst_inactive", int'(bus.seq_active), 0);
    chk("arst_slot", int'(bus.slot_idx), 0);
    chk("arst_cfg_ready", int'(bus.cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    launch(3, 0, 1);
    wait_idle(2000);

`ifdef TAP_SEQ_EDGE_CNT_EN
    for (int s = 0; s < NS; s++) cfg_write(s, 0, 255);
    launch(3, 0, 1);
    wait_idle(6000);
    chk("edge_count_1020", int'(bus.edge_count), 1020);
    launch(0, 0, 1);
    chk("edge_count_clear", int'(bus.edge_count), 0);
    wait_idle(2000);
    chk("edge_count_255", int'(bus.edge_count), 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
